mem_scan_display: RTL and testbench
===================================

# mem_scan_display

Read-only memory walker feeding the board's six seven-segment digits. It drives the top level's idle memory address (the port selected when `mem_control_enable` is low) and steps through words 0..SCAN_DEPTH-1. For each word it shows the low half, then the high half, on six hex nibbles that go to the downstream `hexTo7seg` decoders. It backs off whenever the programming controller owns the memory, and provides pause/single-step from push buttons.

## Interface
- `MEM_ADDR_WIDTH`, 10: memory address width.
- `MEM_DATA_WIDTH`, 32: word width; fixed at 32.
- `SCAN_DEPTH`, 128: words scanned, wraps after SCAN_DEPTH-1; must be ≤ 2^MEM_ADDR_WIDTH.
- `DWELL_CYCLES`, 5_000_000: clk cycles each half-word stays on display (0.5 s at 10 MHz); ≥ 2.
- `DEBOUNCE_CYCLES`, 100_000: stable cycles required by the debouncer (only with SCAN_DEBOUNCE_EN).
- `clk`  in  1  system clock (PLL output).
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_busy`  in  1  programming controller owns memory (`mem_control_enable`).
- `rd_addr`  out  MEM_ADDR_WIDTH  read address to memory idle port.
- `rd_data`  in  32  memory read data, valid 1 cycle after `rd_addr` (synchronous RAM).
- `btn_pause`  in  1  asynchronous button, active-high.
- `btn_step`  in  1  asynchronous button, active-high.
- `hex_out`  out  24  six nibbles, [23:20] = digit 6 .. [3:0] = digit 1.
- `half_sel`  out  1  0 = low half shown, 1 = high half shown.
- `paused`  out  1  scan frozen.
- `disp_valid`  out  1  `hex_out` holds a captured word.

## Operation
- Reset values: `rd_addr`=0, `hex_out`=0, `half_sel`=0, `paused`=0, `disp_valid`=0. State=REQ, scan address=0, dwell counter=0.
- Buttons pass through a 2-flop synchronizer and a rising-edge detector. One pulse is produced per press.
- FSM states:
  - REQ: `rd_addr`=scan address. If `mem_busy`=0, go to WAIT. Otherwise stay in REQ.
  - WAIT: one latency cycle. If `mem_busy`=1 in this cycle, the data is void; go back to REQ. Otherwise go to CAPTURE.
  - CAPTURE: latch `rd_data` into an internal word register, set `disp_valid`=1 and `half_sel`=0, clear the dwell counter, go to SHOW.
  - SHOW: the dwell counter increments while not paused. When it reaches DWELL_CYCLES-1 with `half_sel`=0, set `half_sel`=1 and clear the counter. When it reaches DWELL_CYCLES-1 with `half_sel`=1, advance the scan address and go to REQ.
- `hex_out` = {scan_addr[7:0], word[15:0]} when `half_sel`=0, or {scan_addr[7:0], word[31:16]} when `half_sel`=1. Unused upper address bits read as 0 when MEM_ADDR_WIDTH < 8.
- Address advance: SCAN_DEPTH-1 wraps to 0.
- `mem_busy` in SHOW has no effect; the display holds the last captured word.
- A pause pulse toggles `paused`. While paused, the dwell counter freezes.
- A step pulse while paused in SHOW advances the address immediately and goes to REQ. A step pulse when not paused, or outside SHOW, is dropped.
- If pause and step pulses arrive in the same cycle, the pause is applied and the step is dropped.
- `rd_addr` is held at the scan address in every state, so the memory port never sees an unrequested address change.

## Timing
- Read latency with `mem_busy`=0: REQ→WAIT→CAPTURE→SHOW. New `hex_out` appears 3 cycles after entering REQ.
- First capture after reset release: `hex_out` shows word 0 at cycle 3. `disp_valid` rises in the same cycle.
- Each word occupies 3 + 2·DWELL_CYCLES cycles when unpaused and `mem_busy`=0.
- Button pulse is registered 3 cycles after the pin edge (2 sync + 1 edge detect), plus DEBOUNCE_CYCLES when the debouncer is enabled.
- Reset mid-operation: all state returns to reset values asynchronously. The scan restarts at address 0 on the first clk edge after `rst_n` rises.
- `mem_busy` held high indefinitely: the FSM stays in REQ, `hex_out` is unchanged, and there is no timeout.

## Configuration
- `SCAN_DEBOUNCE_EN` defined: each synchronized button feeds a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a stable, differing input, and edge detection runs on the debounced level.
- `SCAN_DEBOUNCE_EN` undefined: edge detection runs directly on the synchronizer output. DEBOUNCE_CYCLES is unused.

## Test plan
- Memory preloaded with word0=32'hDEADBEEF, word1=32'h12345678; DWELL_CYCLES=4; release reset → `hex_out`=24'h00BEEF, then 24'h00DEAD, then 24'h015678, then 24'h011234.
- SCAN_DEPTH=2 → after word 1's high half, `rd_addr` wraps to 0 and `hex_out`=24'h00BEEF.
- `mem_busy` asserted exactly in WAIT → FSM returns to REQ and no capture occurs. After `mem_busy` drops, the correct word is captured 3 cycles later.
- Pause pulse during SHOW → `paused`=1 and `hex_out` frozen for 100 cycles. A step pulse then → next word appears 3 cycles later with `half_sel`=0.
- Pause and step pulses in the same cycle while unpaused → `paused`=1, address unchanged.
- `rst_n` pulsed low during SHOW of word 1 → all outputs are 0 immediately. After release, word 0 is displayed at cycle 3.

Source files
------------

// File: rtl/mem_scan_display.sv
// Read-only memory walker for the six-digit hex display: scans words 0..SCAN_DEPTH-1, low half then high half.
// Define SCAN_DEBOUNCE_EN to insert a stable-level debouncer between the button synchronizers and edge detectors.
module mem_scan_display #(
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int SCAN_DEPTH      = 128,
  parameter int DWELL_CYCLES    = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_busy,
  output logic [MEM_ADDR_WIDTH-1:0] rd_addr,
  input  logic [MEM_DATA_WIDTH-1:0] rd_data,
  input  logic                      btn_pause,
  input  logic                      btn_step,
  output logic [23:0]               hex_out,
  output logic                      half_sel,
  output logic                      paused,
  output logic                      disp_valid,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(SCAN_DEPTH - 1);

  if (DWELL_CYCLES < 2 || SCAN_DEPTH < 1 || SCAN_DEPTH > (1 << MEM_ADDR_WIDTH) ||
      MEM_DATA_WIDTH != 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("mem_scan_display: illegal parameter combination");
  end

  // Buttons: bit 0 = pause, bit 1 = step.
  logic [1:0] btn_raw, sync1, sync2, level, level_d, pulse;
  assign btn_raw = {btn_step, btn_pause};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
    end
  end

`ifdef SCAN_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       deb_level;

  // The level follows the input only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_level[i] <= sync2[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
  assign level = deb_level;
`else
  assign level = sync2;
`endif

  assign pulse = level & ~level_d;

  logic                      pause_pulse, step_pulse;
  assign pause_pulse = pulse[0];
  assign step_pulse  = pulse[1];

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] scan_addr, next_addr;
  logic [DW-1:0]             dwell;
  logic [15:0]               word_hi;
  logic [7:0]                addr_byte;

  if (MEM_ADDR_WIDTH >= 8) begin : g_addr_wide
    assign addr_byte = scan_addr[7:0];
  end else begin : g_addr_narrow
    assign addr_byte = {{(8 - MEM_ADDR_WIDTH){1'b0}}, scan_addr};
  end

  assign next_addr = (scan_addr == ADDR_LAST) ? '0 : scan_addr + 1'b1;
  assign rd_addr   = scan_addr;
  assign state_dbg = state;

  // disp_valid is a level, not a handshake: once the first word is captured it stays high until reset,
  // and hex_out is only rewritten on a capture or a half switch, so it never shows a torn word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      scan_addr  <= '0;
      dwell      <= '0;
      word_hi    <= '0;
      hex_out    <= '0;
      half_sel   <= 1'b0;
      paused     <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      if (pause_pulse) paused <= ~paused;
      case (state)
        ST_REQ: begin
          if (!mem_busy) state <= ST_WAIT;
        end
        ST_WAIT: begin
          state <= mem_busy ? ST_REQ : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          word_hi    <= rd_data[31:16];
          hex_out    <= {addr_byte, rd_data[15:0]};
          disp_valid <= 1'b1;
          half_sel   <= 1'b0;
          dwell      <= '0;
          state      <= ST_SHOW;
        end
        ST_SHOW: begin
          // Pause wins over a simultaneous step; stepping only acts on an already-paused scan.
          if (step_pulse && paused && !pause_pulse) begin
            scan_addr <= next_addr;
            dwell     <= '0;
            state     <= ST_REQ;
          end else if (!paused) begin
            if (dwell == DWELL_LAST) begin
              dwell <= '0;
              if (!half_sel) begin
                half_sel <= 1'b1;
                hex_out  <= {hex_out[23:16], word_hi};
              end else begin
                scan_addr <= next_addr;
                state     <= ST_REQ;
              end
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_display.sv
// Directed bench for mem_scan_display: two-word memory, short dwell, busy back-off, pause/step and reset.
module tb_mem_scan_display;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          mem_busy;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          btn_pause;
  logic          btn_step;
  logic [23:0]   hex_out;
  logic          half_sel;
  logic          paused;
  logic          disp_valid;
  logic [1:0]    state_dbg;

  logic [31:0]   mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  // Each entry is {half_sel, hex_out} for the next display change.
  logic [24:0] exp_q[$];

  mem_scan_display #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (32),
    .SCAN_DEPTH     (2),
    .DWELL_CYCLES   (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_busy  (mem_busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .btn_pause (btn_pause),
    .btn_step  (btn_step),
    .hex_out   (hex_out),
    .half_sel  (half_sel),
    .paused    (paused),
    .disp_valid(disp_valid),
    .state_dbg (state_dbg)
  );

  // Clock / reset / memory model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h12345678;
  end

  always @(posedge clk) rd_data <= mem[rd_addr];

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic press(input logic p, input logic s);
    btn_pause = p;
    btn_step  = s;
    tick(1);
    btn_pause = 1'b0;
    btn_step  = 1'b0;
  endtask

  // Scoreboard monitor: compares every change of the displayed value against the queue head
  logic [24:0] prev_obs;
  logic [24:0] obs;
  logic [24:0] exp_v;
  initial begin
    prev_obs = '0;
    forever begin
      @(negedge clk);
      obs = {half_sel, hex_out};
      if (!rst_n) begin
        prev_obs = '0;
      end else if (disp_valid && obs !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL display_unexpected actual=%h expected=none", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            failures++;
            $display("FAIL display_seq actual=%h expected=%h", obs, exp_v);
          end
        end
        prev_obs = obs;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mem_busy  = 1'b0;
    btn_pause = 1'b0;
    btn_step  = 1'b0;
    tick(3);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_hex_out", 32'(hex_out), 32'h0);
    check("rst_half_sel", 32'(half_sel), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_disp_valid", 32'(disp_valid), 32'h0);

    // Free-running scan with wrap after word 1
    exp_q.push_back({1'b0, 24'h00BEEF});
    exp_q.push_back({1'b1, 24'h00DEAD});
    exp_q.push_back({1'b0, 24'h015678});
    exp_q.push_back({1'b1, 24'h011234});
    exp_q.push_back({1'b0, 24'h00BEEF});
    exp_q.push_back({1'b1, 24'h00DEAD});
    exp_q.push_back({1'b0, 24'h015678});
    rst_n = 1'b1;
    tick(2);
    check("first_valid_early", 32'(disp_valid), 32'h0);
    tick(1);
    check("first_valid_c3", 32'(disp_valid), 32'h1);
    check("first_hex_c3", 32'(hex_out), 32'h00BEEF);
    tick(4);
    check("w0_high_half", 32'(hex_out), 32'h00DEAD);
    check("w0_half_sel", 32'(half_sel), 32'h1);
    tick(4);
    check("advance_addr1", 32'(rd_addr), 32'h1);
    tick(3);
    check("w1_low_half", 32'(hex_out), 32'h015678);
    tick(8);
    check("wrap_addr0", 32'(rd_addr), 32'h0);
    tick(3);
    check("wrap_hex", 32'(hex_out), 32'h00BEEF);

    // Busy during the latency cycle voids the read
    tick(9);
    check("in_wait", 32'(state_dbg), 32'h1);
    mem_busy = 1'b1;
    tick(1);
    check("busy_back_to_req", 32'(state_dbg), 32'h0);
    tick(5);
    check("busy_hold_req", 32'(state_dbg), 32'h0);
    check("busy_hex_held", 32'(hex_out), 32'h00DEAD);
    mem_busy = 1'b0;
    tick(2);
    check("busy_no_early_capture", 32'(hex_out), 32'h00DEAD);
    tick(1);
    check("busy_recapture", 32'(hex_out), 32'h015678);
    check("busy_recapture_addr", 32'(rd_addr), 32'h1);

    // Pause freezes the display
    press(1'b1, 1'b0);
    for (int i = 0; i < 10 && !paused; i++) tick(1);
    check("pause_set", 32'(paused), 32'h1);
    tick(100);
    check("pause_hex_frozen", 32'(hex_out), 32'h015678);
    check("pause_half_frozen", 32'(half_sel), 32'h0);
    check("pause_state_show", 32'(state_dbg), 32'h3);

    // Step while paused jumps to the next word
    exp_q.push_back({1'b0, 24'h00BEEF});
    press(1'b0, 1'b1);
    for (int i = 0; i < 10 && state_dbg != 2'd0; i++) tick(1);
    check("step_to_req", 32'(state_dbg), 32'h0);
    tick(2);
    check("step_no_early", 32'(hex_out), 32'h015678);
    tick(1);
    check("step_hex", 32'(hex_out), 32'h00BEEF);
    check("step_half_sel", 32'(half_sel), 32'h0);
    check("step_still_paused", 32'(paused), 32'h1);

    // Unpause, then pause+step together: pause wins, step dropped
    press(1'b1, 1'b0);
    for (int i = 0; i < 10 && paused; i++) tick(1);
    check("unpause", 32'(paused), 32'h0);
    press(1'b1, 1'b1);
    for (int i = 0; i < 10 && !paused; i++) tick(1);
    check("both_paused", 32'(paused), 32'h1);
    check("both_addr_same", 32'(rd_addr), 32'h0);
    check("both_state_show", 32'(state_dbg), 32'h3);
    tick(10);
    check("both_step_dropped", 32'(state_dbg), 32'h3);
    check("both_hex", 32'(hex_out), 32'h00BEEF);

    // Resume, reach word 1, then reset in the middle of its display
    exp_q.push_back({1'b1, 24'h00DEAD});
    exp_q.push_back({1'b0, 24'h015678});
    press(1'b1, 1'b0);
    for (int i = 0; i < 30 && !(state_dbg == 2'd3 && rd_addr == 10'd1); i++) tick(1);
    check("resume_word1", 32'(hex_out), 32'h015678);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hex", 32'(hex_out), 32'h0);
    check("mid_rst_addr", 32'(rd_addr), 32'h0);
    check("mid_rst_half", 32'(half_sel), 32'h0);
    check("mid_rst_paused", 32'(paused), 32'h0);
    check("mid_rst_valid", 32'(disp_valid), 32'h0);
    tick(2);
    exp_q.push_back({1'b0, 24'h00BEEF});
    rst_n = 1'b1;
    tick(2);
    check("rerst_valid_early", 32'(disp_valid), 32'h0);
    tick(1);
    check("rerst_hex_c3", 32'(hex_out), 32'h00BEEF);
    check("rerst_valid_c3", 32'(disp_valid), 32'h1);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
